// File: rtl/mcu_pkg.sv
// Shared encodings for the playlist controller: state, repeat modes and shuffle LFSR constants.
package mcu_pkg;

  typedef enum logic {
    MCU_PAUSE = 1'b0,
    MCU_PLAY  = 1'b1
  } mcu_state_t;

  localparam logic [1:0] RPT_OFF = 2'd0;
  localparam logic [1:0] RPT_ALL = 2'd1;
  localparam logic [1:0] RPT_ONE = 2'd2;

  // Fibonacci taps 16,14,13,11 expressed as a bit mask over lfsr[15:0]
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/dffr.sv
// Generic register with synchronous active-high reset to a configurable value.
module dffr #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VAL;
    else       q <= d;
  end

endmodule

// File: rtl/song_step.sv
// Combinational wrapped step of a song index; DOWN selects decrement instead of increment.
module song_step #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_WIDTH = 2,
  parameter bit DOWN       = 1'b0
) (
  input  logic [SONG_WIDTH-1:0] song,
  output logic [SONG_WIDTH-1:0] step
);

  // Explicit compare against the last index so non-power-of-two counts wrap correctly
  localparam logic [SONG_WIDTH-1:0] LAST = SONG_WIDTH'(NUM_SONGS - 1);

  always_comb begin
    if (DOWN) step = (song == '0)   ? LAST : song - SONG_WIDTH'(1);
    else      step = (song == LAST) ? '0   : song + SONG_WIDTH'(1);
  end

endmodule

// File: rtl/playlist_mcu.sv
// Playlist controller: song index, play/pause, repeat modes and autoplay.
// Optional shuffle playback is enabled by defining SHUFFLE_EN.
module playlist_mcu
  import mcu_pkg::*;
#(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_button,
  input  logic                  next_button,
  input  logic                  prev_button,
  input  logic                  song_done,
  input  logic [1:0]            repeat_mode,
  input  logic                  shuffle,
  output logic                  play,
  output logic                  reset_player,
  output logic [SONG_WIDTH-1:0] song,
  output logic                  playlist_done
);

  localparam logic [SONG_WIDTH-1:0] LAST = SONG_WIDTH'(NUM_SONGS - 1);

  mcu_state_t            state, state_d;
  logic                  state_bit;
  logic [SONG_WIDTH-1:0] song_q, song_d, song_inc, song_dec;
  logic [SONG_WIDTH-1:0] adv_song, back_song;
  logic                  at_end;
  logic                  rp_d, pd_d;
  logic                  advanced, song_chg, play_start;

  song_step #(.NUM_SONGS(NUM_SONGS), .SONG_WIDTH(SONG_WIDTH), .DOWN(1'b0)) u_next_step (
    .song (song_q),
    .step (song_inc)
  );

  song_step #(.NUM_SONGS(NUM_SONGS), .SONG_WIDTH(SONG_WIDTH), .DOWN(1'b1)) u_prev_step (
    .song (song_q),
    .step (song_dec)
  );

  dffr #(.WIDTH(1))          u_state_reg (.clk(clk), .reset(reset), .d(state_d), .q(state_bit));
  dffr #(.WIDTH(SONG_WIDTH)) u_song_reg  (.clk(clk), .reset(reset), .d(song_d),  .q(song_q));
  dffr #(.WIDTH(1))          u_rp_reg    (.clk(clk), .reset(reset), .d(rp_d),    .q(reset_player));
  dffr #(.WIDTH(1))          u_pd_reg    (.clk(clk), .reset(reset), .d(pd_d),    .q(playlist_done));

  assign state = mcu_state_t'(state_bit);
  assign play  = (state == MCU_PLAY);
  assign song  = song_q;

  // Only the highest-priority event acts: next > prev > song_done > play
  always_comb begin
    state_d    = state;
    song_d     = song_q;
    rp_d       = 1'b0;
    pd_d       = 1'b0;
    advanced   = 1'b0;
    song_chg   = 1'b0;
    play_start = 1'b0;
    if (next_button) begin
      song_d   = adv_song;
      rp_d     = 1'b1;
      advanced = 1'b1;
      song_chg = 1'b1;
    end else if (prev_button) begin
      song_d   = back_song;
      rp_d     = 1'b1;
      song_chg = 1'b1;
    end else if (song_done && state == MCU_PLAY) begin
      rp_d = 1'b1;
      if (repeat_mode == RPT_OFF && at_end) begin
        song_d   = '0;
        state_d  = MCU_PAUSE;
        pd_d     = 1'b1;
        song_chg = 1'b1;
      end else if (repeat_mode != RPT_ONE) begin
        song_d   = adv_song;
        advanced = 1'b1;
        song_chg = 1'b1;
      end
    end else if (play_button) begin
      state_d    = (state == MCU_PLAY) ? MCU_PAUSE : MCU_PLAY;
      play_start = (state == MCU_PAUSE);
    end
  end

`ifdef SHUFFLE_EN
  logic [15:0]           lfsr_q, lfsr_d;
  logic [SONG_WIDTH-1:0] cand, hist_q, hist_d, cnt_q, cnt_d;
  logic                  hist_v_q, hist_v_d;

  dffr #(.WIDTH(16), .RESET_VAL(LFSR_SEED)) u_lfsr_reg (.clk(clk), .reset(reset), .d(lfsr_d), .q(lfsr_q));
  dffr #(.WIDTH(SONG_WIDTH)) u_hist_reg   (.clk(clk), .reset(reset), .d(hist_d),   .q(hist_q));
  dffr #(.WIDTH(1))          u_hist_v_reg (.clk(clk), .reset(reset), .d(hist_v_d), .q(hist_v_q));
  dffr #(.WIDTH(SONG_WIDTH)) u_cnt_reg    (.clk(clk), .reset(reset), .d(cnt_d),    .q(cnt_q));

  assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

  // Fold the raw LFSR bits into range and never pick the song already playing
  always_comb begin
    cand = lfsr_q[SONG_WIDTH-1:0];
    if ({1'b0, cand} >= (SONG_WIDTH+1)'(NUM_SONGS)) cand = cand - SONG_WIDTH'(NUM_SONGS);
    if (cand == song_q) cand = song_inc;
  end

  assign adv_song  = shuffle ? cand : song_inc;
  assign back_song = (shuffle && hist_v_q) ? hist_q : song_dec;
  assign at_end    = shuffle ? (cnt_q == LAST) : (song_q == LAST);

  // In shuffle the end of the list is a count of advances, restarted when play begins at song 0
  always_comb begin
    hist_d   = hist_q;
    hist_v_d = hist_v_q;
    cnt_d    = cnt_q;
    if (song_chg) begin
      hist_d   = song_q;
      hist_v_d = 1'b1;
    end
    if (advanced && shuffle && cnt_q != LAST) cnt_d = cnt_q + SONG_WIDTH'(1);
    if (pd_d || (play_start && song_q == '0)) cnt_d = '0;
  end
`else
  assign adv_song  = song_inc;
  assign back_song = song_dec;
  assign at_end    = (song_q == LAST);

  logic unused_bits;
  assign unused_bits = ^{shuffle, advanced, song_chg, play_start};
`endif

endmodule

// File: doc/playlist_mcu.md
Name: playlist_mcu

Overview:
- Parametrised successor to the 4-song play/pause controller in the music synth.
- Sits between the debounced front-panel buttons and the song player. Tracks the current song index and the play/pause state, and issues a one-cycle reset_player pulse on every song change.
- Adds over the previous generation: configurable song count (not limited to a power of two), a previous-song button, repeat modes, and autoplay on song_done. The next button no longer forces pause.

Parameters:
- NUM_SONGS, 4: number of songs in the ROM; legal range 2..2**SONG_WIDTH.
- SONG_WIDTH, 2: width of the song index; must equal clog2(NUM_SONGS).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- play_button  input  1  one-cycle pulse; toggles play/pause
- next_button  input  1  one-cycle pulse; advance one song
- prev_button  input  1  one-cycle pulse; go back one song
- song_done  input  1  one-cycle pulse from player at end of song
- repeat_mode  input  2  0=OFF, 1=ALL, 2=ONE, 3 treated as ALL
- shuffle  input  1  shuffle request; ignored unless SHUFFLE_EN
- play  output  1  player enable
- reset_player  output  1  one-cycle pulse; restart player at new/same song
- song  output  SONG_WIDTH  current song index
- playlist_done  output  1  one-cycle pulse when REPEAT OFF reaches the end of the list

Behaviour:
- Clock and reset:
  - Single clock domain, clk.
  - reset is synchronous and active-high, sampled on the rising edge of clk.
- Registers:
  - All outputs are registered.
  - An input sampled at edge N is reflected on the outputs after edge N+1. There is no combinational input-to-output path.
- Reset values: play=0, reset_player=0, song=0, playlist_done=0, state=PAUSE.
- States: PAUSE, PLAY. play is 1 iff state==PLAY.
- Priority within one cycle: next_button > prev_button > song_done > play_button. Only the highest-priority event acts; lower ones are dropped.
- next_button, either state:
  - song <= (song==NUM_SONGS-1) ? 0 : song+1.
  - reset_player pulses.
  - State is unchanged.
- prev_button, either state:
  - song <= (song==0) ? NUM_SONGS-1 : song-1.
  - reset_player pulses.
  - State is unchanged.
- song_done in PAUSE: ignored.
- song_done in PLAY:
  - repeat ONE: song unchanged, reset_player pulses, stay PLAY.
  - repeat ALL: song advances with wrap, reset_player pulses, stay PLAY.
  - repeat OFF, song < NUM_SONGS-1: song+1, reset_player pulses, stay PLAY.
  - repeat OFF, song == NUM_SONGS-1: song <= 0, reset_player pulses, state <= PAUSE, playlist_done pulses.
- play_button: PAUSE -> PLAY; PLAY -> PAUSE. song and reset_player are unaffected.
- Pulse width: reset_player and playlist_done are high for exactly one cycle per triggering event. Back-to-back events give back-to-back pulses.
- repeat_mode is sampled only in the cycle song_done acts. Changing it mid-song has no other effect.
- Reset mid-operation overrides all inputs in that cycle. Outputs return to reset values on the next edge, and no reset_player pulse is issued.
- Wrap arithmetic:
  - Compare against NUM_SONGS-1 explicitly; never rely on natural SONG_WIDTH overflow.
  - song must never hold a value >= NUM_SONGS.

Optional Feature:
- Macro: SHUFFLE_EN.
- With SHUFFLE_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every cycle.
  - When shuffle=1, every song-advance event (next_button, repeat ALL/OFF song_done) computes a candidate: c = lfsr[SONG_WIDTH-1:0]; if c >= NUM_SONGS then c - NUM_SONGS.
  - If the candidate equals the current song, use the wrapped song+1 instead.
  - A one-deep history register holds the previous index. prev_button in shuffle returns to that index; if the history is invalid (immediately after reset), it falls back to the wrapped song-1.
  - The repeat OFF end-of-list condition counts advances: playlist_done fires after NUM_SONGS-1 shuffled advances since the last reset or play start from song 0.
- Without SHUFFLE_EN: no LFSR or history logic is present; the shuffle port exists but is ignored.

Decomposition:
- Package mcu_pkg holds:
  - the state encoding (MCU_PAUSE=1'b0, MCU_PLAY=1'b1);
  - repeat-mode constants (RPT_OFF, RPT_ALL, RPT_ONE);
  - the LFSR seed and taps.
- State and song registers use the existing dffr flop.
- One sub-module is natural: song_step. It is combinational and parametrised by NUM_SONGS/SONG_WIDTH, producing the wrapped increment and decrement of an index. Both instances (next, prev) live inside playlist_mcu.

Test Plan:
- Reset, then NUM_SONGS=3, next_button pulsed 4 times in PAUSE -> song 1,2,0,1; reset_player high exactly 4 single cycles; play stays 0.
- PLAY, song=2, NUM_SONGS=3, repeat OFF, song_done -> next cycle song=0, play=0, reset_player=1, playlist_done=1; both pulses low the cycle after.
- PLAY, song=1, repeat ONE, song_done -> song stays 1, play stays 1, reset_player 1 for one cycle.
- Same cycle: next_button + prev_button + play_button, song=0, PLAY -> song=1, still PLAY (play_button dropped).
- song=0, prev_button -> song=NUM_SONGS-1; reset asserted in the same cycle as next_button -> song=0, play=0, reset_player=0.
- SHUFFLE_EN, shuffle=1, 50 next_button pulses -> song always < NUM_SONGS, never repeats consecutively; prev_button restores the prior index.
